traffic_spawn_scheduler: RTL and testbench

//  Multi-lane traffic spawner for the game controller. Once per frame it

---
 rtl/traffic_spawn_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_traffic_spawn_scheduler.sv | 545 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_spawn_scheduler.sv
// traffic_spawn_scheduler: once per frame draws a random number, picks a
// free lane and vehicle type, and hands a spawn request to the object pool.
module traffic_spawn_scheduler #(
    parameter int                LANES           = 4,
    parameter int                LEVEL_W         = 3,
    parameter int                LFSR_W          = 16,
    parameter logic [LFSR_W-1:0] SEED            = LFSR_W'(16'hACE1),
    parameter int                COOLDOWN        = 30,
    parameter int                CD_W            = 8,
    parameter int                TRUCK_MIN_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     frame_tick,
    input  logic                     enable,
    input  logic [LEVEL_W-1:0]       level,
    input  logic                     spawn_ack,
    output logic                     spawn_req,
    output logic [$clog2(LANES)-1:0] spawn_lane,
    output logic                     spawn_truck,
    output logic [7:0]               drop_cnt
);

    localparam int LANE_W = $clog2(LANES);

    // Right-shifting Galois masks of maximal-length polynomials.
    function automatic logic [LFSR_W-1:0] f_taps();
        logic [31:0] t;
        case (LFSR_W)
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0E08;
            13:      t = 32'h0000_1C80;
            14:      t = 32'h0000_3802;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_B400;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0007_2000;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_B400;
        endcase
        return LFSR_W'(t);
    endfunction

    localparam logic [LFSR_W-1:0] TAPS = f_taps();
    localparam logic [LFSR_W-1:0] SEED_NZ =
        (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [LEVEL_W-1:0] TRUCK_LVL =
        LEVEL_W'(TRUCK_MIN_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECIDE,
        S_REQ
    } state_t;

    state_t              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   w_lfsr_nxt;
    logic                r_frame_d;
    logic                w_fr_edge;
    logic [LEVEL_W-1:0]  r_rnd_lvl;
    logic [LANE_W-1:0]   r_rnd_lane;
    logic                r_rnd_msb;
    logic [CD_W-1:0]     r_cd [LANES];
    logic                r_spawn_req;
    logic [LANE_W-1:0]   r_spawn_lane;
    logic                r_spawn_truck;
    logic [7:0]          r_drop;
    logic                w_go;
    logic                w_found;
    logic [LANE_W-1:0]   w_cand;
    logic [LANE_W-1:0]   w_lane;
    logic                w_truck;
    logic                w_ack;
    logic                w_busy_drop;
    logic                w_block_drop;
    logic [1:0]          w_drop_inc;
    logic [8:0]          w_drop_sum;
    logic [7:0]          w_drop_nxt;

    assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS)
                                  : (r_lfsr >> 1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lfsr    <= SEED_NZ;
            r_frame_d <= 1'b0;
        end else begin
            r_lfsr    <= w_lfsr_nxt;
            r_frame_d <= frame_tick;
        end
    end

    assign w_fr_edge = frame_tick & ~r_frame_d;

    assign w_go    = (r_rnd_lvl >= level);
    assign w_cand  = LANE_W'(r_rnd_lane % LANES);
    assign w_truck = r_rnd_msb & (level >= TRUCK_LVL);

    // First free lane, scanning upward from the candidate with wrap.
    always_comb begin
        w_found = 1'b0;
        w_lane  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (!w_found &&
                r_cd[(int'(w_cand) + k) % LANES] == '0) begin
                w_found = 1'b1;
                w_lane  = LANE_W'((int'(w_cand) + k) % LANES);
            end
        end
    end

    assign w_ack = (r_state == S_REQ) & enable
                 & r_spawn_req & spawn_ack;

    assign w_busy_drop  = w_fr_edge & (r_state != S_IDLE);
    assign w_block_drop = (r_state == S_DECIDE) & enable
                        & w_go & ~w_found;
    assign w_drop_inc   = {1'b0, w_busy_drop}
                        + {1'b0, w_block_drop};
    assign w_drop_sum   = {1'b0, r_drop} + {7'b0, w_drop_inc};
    assign w_drop_nxt   = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_rnd_lvl     <= '0;
            r_rnd_lane    <= '0;
            r_rnd_msb     <= 1'b0;
            r_spawn_req   <= 1'b0;
            r_spawn_lane  <= '0;
            r_spawn_truck <= 1'b0;
            r_drop        <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_cd[i] <= '0;
            end
        end else begin
            r_drop <= w_drop_nxt;
            // An accepted spawn reloads its lane even on a frame edge.
            for (int i = 0; i < LANES; i++) begin
                if (w_ack && r_spawn_lane == LANE_W'(i)) begin
                    r_cd[i] <= CD_LOAD;
                end else if (w_fr_edge && r_cd[i] != '0) begin
                    r_cd[i] <= r_cd[i] - CD_W'(1);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fr_edge && enable) begin
                        r_rnd_lvl  <= r_lfsr[LEVEL_W-1:0];
                        r_rnd_lane <= r_lfsr[LEVEL_W +: LANE_W];
                        r_rnd_msb  <= r_lfsr[LFSR_W-1];
                        r_state    <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    r_state <= S_IDLE;
                    if (enable && w_go && w_found) begin
                        r_spawn_lane  <= w_lane;
                        r_spawn_truck <= w_truck;
                        r_spawn_req   <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!enable || w_ack) begin
                        r_spawn_req <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_spawn_req <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign spawn_req   = r_spawn_req;
    assign spawn_lane  = r_spawn_lane;
    assign spawn_truck = r_spawn_truck;
    assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_traffic_spawn_scheduler.sv
// tb_traffic_spawn_scheduler: randomized frame/ack stimulus checked
// against a lane/cooldown reference model.
`timescale 1ns/1ps
module tb_traffic_spawn_scheduler;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       spawn_ack = 1'b0;
    logic [2:0] level = 3'd0;
    logic       spawn_req;
    logic [1:0] spawn_lane;
    logic       spawn_truck;
    logic [7:0] drop_cnt;
    logic       z_req;
    logic [1:0] z_lane;
    logic       z_truck;
    logic [7:0] z_drop;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_cd [4];
    int          m_drop;

    always #5 clk = ~clk;

    traffic_spawn_scheduler u_dut (
        .clk(clk), .resetN(resetN), .frame_tick(frame_tick),
        .enable(enable), .level(level), .spawn_ack(spawn_ack),
        .spawn_req(spawn_req), .spawn_lane(spawn_lane),
        .spawn_truck(spawn_truck), .drop_cnt(drop_cnt)
    );

    traffic_spawn_scheduler #(.SEED(16'h0000)) u_dut0 (
        .clk(clk), .resetN(resetN), .frame_tick(frame_tick),
        .enable(enable), .level(level), .spawn_ack(spawn_ack),
        .spawn_req(z_req), .spawn_lane(z_lane),
        .spawn_truck(z_truck), .drop_cnt(z_drop)
    );

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shift Galois form
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) m_lfsr <= 16'hACE1;
        else         m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic void predict(
        input  logic [15:0] rnd, input logic [2:0] lvl,
        output bit go, output bit found,
        output int lane, output bit truck);
        int c;
        go    = (rnd[2:0] >= lvl);
        c     = int'(rnd[4:3]) % 4;
        found = 1'b0;
        lane  = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && m_cd[(c + k) % 4] == 0) begin
                found = 1'b1;
                lane  = (c + k) % 4;
            end
        end
        truck = rnd[15] && (lvl >= 3'd2);
    endfunction

    function automatic int cd_mismatch();
        int n = 0;
        for (int i = 0; i < 4; i++)
            if (int'(u_dut.r_cd[i]) != m_cd[i]) n++;
        return n;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        resetN = 1'b0;
        frame_tick = 1'b0;
        enable = 1'b0;
        spawn_ack = 1'b0;
        for (int i = 0; i < 4; i++) m_cd[i] = 0;
        m_drop = 0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic wait_rnd(input logic [15:0] mask,
                            input logic [15:0] val);
        int n = 0;
        @(negedge clk);
        while ((m_lfsr & mask) != val && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if ((m_lfsr & mask) != val) begin
            checks++;
            errors++;
            $display("FAIL wait_rnd: lfsr=%h never hit %h/%h",
                     m_lfsr, val, mask);
        end
    endtask

    task automatic fire(output logic [15:0] rnd);
        rnd = m_lfsr;
        frame_tick = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (m_cd[i] > 0) m_cd[i]--;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_ack(input int lane);
        spawn_ack = 1'b1;
        @(posedge clk);
        m_cd[lane] = 30;
        @(negedge clk);
        spawn_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        for (int i = 0; i < 4; i++) m_cd[i] = 0;
        m_drop = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spawn_req, spawn_lane, spawn_truck, drop_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outs: got req=%b lane=%0d trk=%b drop=%0d want 0",
                     spawn_req, spawn_lane, spawn_truck, drop_cnt);
        end
        checks++;
        if (u_dut0.r_lfsr !== 16'h0001) begin
            errors++;
            $display("FAIL reset_seed0: lfsr=%h want 0001", u_dut0.r_lfsr);
        end
        checks++;
        if (u_dut.r_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_seed: lfsr=%h want ace1", u_dut.r_lfsr);
        end
        checks++;
        if (cd_mismatch() != 0) begin
            errors++;
            $display("FAIL reset_cd: %0d lanes nonzero want 0", cd_mismatch());
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_lfsr();
        int zeros = 0;
        int mism = 0;
        int first = 0;
        for (int i = 1; i <= 65536; i++) begin
            @(posedge clk);
            #1;
            if (u_dut.r_lfsr == 16'h0 || u_dut0.r_lfsr == 16'h0) zeros++;
            if (u_dut.r_lfsr != m_lfsr) mism++;
            if (first == 0 && u_dut.r_lfsr == 16'hACE1) first = i;
        end
        checks++;
        if (zeros != 0) begin
            errors++;
            $display("FAIL lfsr_zero: %0d zero states want 0", zeros);
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL lfsr_seq: %0d mismatches want 0", mism);
        end
        checks++;
        if (first != 65535) begin
            errors++;
            $display("FAIL lfsr_period: got %0d want 65535", first);
        end
    endtask

    task automatic test_basic();
        logic [15:0] rnd;
        bit go, found, trk;
        int lane;
        int bad = 0;
        level = 3'd0;
        enable = 1'b1;
        wait_rnd(16'h0, 16'h0);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        fire(rnd);
        predict(rnd, level, go, found, lane, trk);
        checks++;
        if (spawn_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: req=%b want 0", spawn_req);
        end
        @(negedge clk);
        checks++;
        if (spawn_req !== 1'b1 || spawn_lane !== 2'(lane) ||
            spawn_truck !== 1'b0) begin
            errors++;
            $display("FAIL basic_req: req=%b lane=%0d trk=%b want 1 %0d 0",
                     spawn_req, spawn_lane, spawn_truck, lane);
        end
        repeat (2) begin
            @(negedge clk);
            if (spawn_req !== 1'b1 || spawn_lane !== 2'(lane)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_hold: %0d unstable cycles want 0", bad);
        end
        do_ack(lane);
        checks++;
        if (spawn_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_drop: req=%b want 0", spawn_req);
        end
        checks++;
        if (int'(u_dut.r_cd[lane]) != 30) begin
            errors++;
            $display("FAIL basic_cd: cd=%0d want 30", u_dut.r_cd[lane]);
        end
    endtask

    task automatic test_level();
        logic [15:0] rnd;
        bit go, found, trk;
        int lane;
        level = 3'd7;
        enable = 1'b1;
        wait_rnd(16'h7, 16'h7);
        fire(rnd);
        predict(rnd, level, go, found, lane, trk);
        @(negedge clk);
        checks++;
        if (spawn_req !== 1'b1 || spawn_lane !== 2'(lane) ||
            spawn_truck !== rnd[15]) begin
            errors++;
            $display("FAIL level7_go: req=%b lane=%0d trk=%b want 1 %0d %b",
                     spawn_req, spawn_lane, spawn_truck, lane, rnd[15]);
        end
        do_ack(lane);
        wait_rnd(16'h7, 16'h6);
        fire(rnd);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (spawn_req !== 1'b0 || int'(drop_cnt) != m_drop) begin
            errors++;
            $display("FAIL level7_nogo: req=%b drop=%0d want 0 %0d",
                     spawn_req, drop_cnt, m_drop);
        end
    endtask

    task automatic test_random();
        logic [15:0] rnd;
        bit go, found, trk, en;
        int lane;
        for (int it = 0; it < 40; it++) begin
            level = 3'($urandom_range(0, 7));
            en = ($urandom_range(0, 4) != 0);
            enable = en;
            wait_rnd(16'h0, 16'h0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fire(rnd);
            predict(rnd, level, go, found, lane, trk);
            @(negedge clk);
            if (en && go && found) begin
                checks++;
                if (spawn_req !== 1'b1 || spawn_lane !== 2'(lane) ||
                    spawn_truck !== trk) begin
                    errors++;
                    $display("FAIL rnd_spawn[%0d]: req=%b lane=%0d trk=%b want 1 %0d %b",
                             it, spawn_req, spawn_lane, spawn_truck, lane, trk);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_ack(lane);
            end else begin
                if (en && go) m_drop = sat(m_drop + 1);
                checks++;
                if (spawn_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle[%0d]: req=%b want 0", it, spawn_req);
                end
            end
            checks++;
            if (int'(drop_cnt) != m_drop || cd_mismatch() != 0) begin
                errors++;
                $display("FAIL rnd_state[%0d]: drop=%0d want %0d, cd bad=%0d",
                         it, drop_cnt, m_drop, cd_mismatch());
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_all_blocked();
        logic [15:0] rnd;
        bit go, found, trk;
        int lane;
        int n = 0;
        reset_dut();
        level = 3'd0;
        enable = 1'b1;
        for (int s = 0; s < 4; s++) begin
            wait_rnd(16'h0, 16'h0);
            fire(rnd);
            predict(rnd, level, go, found, lane, trk);
            @(negedge clk);
            checks++;
            if (spawn_req !== 1'b1 || spawn_lane !== 2'(lane)) begin
                errors++;
                $display("FAIL fill[%0d]: req=%b lane=%0d want 1 %0d",
                         s, spawn_req, spawn_lane, lane);
            end
            do_ack(lane);
        end
        wait_rnd(16'h0, 16'h0);
        fire(rnd);
        @(negedge clk);
        m_drop = 1;
        checks++;
        if (spawn_req !== 1'b0 || drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL blocked: req=%b drop=%0d want 0 1",
                     spawn_req, drop_cnt);
        end
        enable = 1'b0;
        while (m_cd[0] > 1 && m_cd[1] > 1 && m_cd[2] > 1 &&
               m_cd[3] > 1 && n < 40) begin
            wait_rnd(16'h0, 16'h0);
            fire(rnd);
            n++;
        end
        checks++;
        if (drop_cnt !== 8'd1 || cd_mismatch() != 0) begin
            errors++;
            $display("FAIL drain: drop=%0d want 1, cd bad=%0d",
                     drop_cnt, cd_mismatch());
        end
        enable = 1'b1;
        wait_rnd(16'h0, 16'h0);
        fire(rnd);
        predict(rnd, level, go, found, lane, trk);
        @(negedge clk);
        checks++;
        if (spawn_req !== 1'b1 || spawn_lane !== 2'(lane) ||
            !found) begin
            errors++;
            $display("FAIL freed: req=%b lane=%0d want 1 %0d",
                     spawn_req, spawn_lane, lane);
        end
        do_ack(lane);
    endtask

    task automatic test_wrap();
        logic [15:0] rnd;
        reset_dut();
        level = 3'd0;
        enable = 1'b1;
        wait_rnd(16'h18, 16'h18);
        fire(rnd);
        @(negedge clk);
        checks++;
        if (spawn_req !== 1'b1 || spawn_lane !== 2'd3) begin
            errors++;
            $display("FAIL wrap_l3: req=%b lane=%0d want 1 3",
                     spawn_req, spawn_lane);
        end
        do_ack(3);
        wait_rnd(16'h18, 16'h18);
        fire(rnd);
        @(negedge clk);
        checks++;
        if (spawn_req !== 1'b1 || spawn_lane !== 2'd0) begin
            errors++;
            $display("FAIL wrap_l0: req=%b lane=%0d want 1 0",
                     spawn_req, spawn_lane);
        end
        do_ack(0);
    endtask

    task automatic test_busy();
        logic [15:0] rnd;
        bit go, found, trk;
        int lane;
        reset_dut();
        level = 3'd0;
        enable = 1'b1;
        wait_rnd(16'h0, 16'h0);
        fire(rnd);
        predict(rnd, level, go, found, lane, trk);
        @(negedge clk);
        repeat (2) begin
            @(negedge clk);
            fire(rnd);
            m_drop = sat(m_drop + 1);
        end
        @(negedge clk);
        checks++;
        if (spawn_req !== 1'b1 || spawn_lane !== 2'(lane) ||
            drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL busy_drop: req=%b lane=%0d drop=%0d want 1 %0d 2",
                     spawn_req, spawn_lane, drop_cnt, lane);
        end
        enable = 1'b0;
        spawn_ack = 1'b1;
        @(negedge clk);
        spawn_ack = 1'b0;
        checks++;
        if (spawn_req !== 1'b0 || int'(u_dut.r_cd[lane]) != m_cd[lane]) begin
            errors++;
            $display("FAIL busy_disable: req=%b cd=%0d want 0 %0d",
                     spawn_req, u_dut.r_cd[lane], m_cd[lane]);
        end
        enable = 1'b1;
        spawn_ack = 1'b1;
        repeat (3) @(negedge clk);
        spawn_ack = 1'b0;
        checks++;
        if (spawn_req !== 1'b0 || int'(drop_cnt) != m_drop ||
            cd_mismatch() != 0) begin
            errors++;
            $display("FAIL stray_ack: req=%b drop=%0d want 0 %0d, cd bad=%0d",
                     spawn_req, drop_cnt, m_drop, cd_mismatch());
        end
    endtask

    task automatic test_drop_sat();
        logic [15:0] rnd;
        bit go, found, trk;
        int lane;
        level = 3'd0;
        enable = 1'b1;
        wait_rnd(16'h0, 16'h0);
        fire(rnd);
        predict(rnd, level, go, found, lane, trk);
        @(negedge clk);
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            fire(rnd);
            m_drop = sat(m_drop + 1);
        end
        @(negedge clk);
        checks++;
        if (drop_cnt !== 8'd255 || spawn_req !== 1'b1) begin
            errors++;
            $display("FAIL drop_sat: drop=%0d req=%b want 255 1",
                     drop_cnt, spawn_req);
        end
        do_ack(lane);
        checks++;
        if (spawn_req !== 1'b0 || cd_mismatch() != 0) begin
            errors++;
            $display("FAIL sat_ack: req=%b want 0, cd bad=%0d",
                     spawn_req, cd_mismatch());
        end
    endtask

    task automatic test_no_truck();
        logic [15:0] rnd;
        bit go, found, trk;
        int lane;
        int bad = 0;
        reset_dut();
        level = 3'd1;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_rnd(16'h0, 16'h0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            fire(rnd);
            predict(rnd, level, go, found, lane, trk);
            @(negedge clk);
            if (go && found) begin
                if (spawn_req !== 1'b1 || spawn_truck !== 1'b0 ||
                    spawn_lane !== 2'(lane)) bad++;
                do_ack(lane);
            end else begin
                if (go) m_drop = sat(m_drop + 1);
                if (spawn_req !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0 || int'(drop_cnt) != m_drop) begin
            errors++;
            $display("FAIL no_truck: bad=%0d drop=%0d want 0 %0d",
                     bad, drop_cnt, m_drop);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rnd;
        level = 3'd0;
        enable = 1'b1;
        wait_rnd(16'h0, 16'h0);
        fire(rnd);
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({spawn_req, spawn_lane, spawn_truck, drop_cnt} !== 12'd0 ||
            u_dut.r_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_mid: req=%b lane=%0d trk=%b drop=%0d want 0",
                     spawn_req, spawn_lane, spawn_truck, drop_cnt);
        end
        for (int i = 0; i < 4; i++) m_cd[i] = 0;
        m_drop = 0;
        checks++;
        if (cd_mismatch() != 0) begin
            errors++;
            $display("FAIL reset_mid_cd: %0d lanes nonzero want 0",
                     cd_mismatch());
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lfsr();
        test_basic();
        test_level();
        test_random();
        test_all_blocked();
        test_wrap();
        test_busy();
        test_drop_sat();
        test_no_truck();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
